// File: rtl/divider_32_pkg.sv
// rtl/divider_32_pkg.sv - shared constants and state encoding for the 32-bit divider
package divider_32_pkg;

  localparam int WIDTH = 32;
  localparam int CNT_W = 5;

  // Number of restoring steps minus one; the counter runs from here down to 0.
  localparam logic [CNT_W-1:0] CNT_INIT = 5'd31;

  // Quotient reported when the divisor is zero.
  localparam logic [WIDTH-1:0] DIV_ZERO_QUOTIENT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div_step_32.sv
// rtl/div_step_32.sv - one combinational restoring division step
module div_step_32
  import divider_32_pkg::*;
(
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] num_in,
  input  logic [WIDTH-1:0] den,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] num_out
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;
  logic           borrow;

  // Shift the next dividend bit into the partial remainder, trial-subtract,
  // restore on borrow and shift the quotient bit into the vacated LSB.
  always_comb begin
    shifted = {rem_in, num_in[WIDTH-1]};
    trial   = shifted - {1'b0, den};
    borrow  = trial[WIDTH];
    rem_out = borrow ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    num_out = {num_in[WIDTH-2:0], ~borrow};
  end

endmodule

// File: rtl/divider_32.sv
// rtl/divider_32.sv - 32-bit restoring divider, optional signed mode via DIVIDER_32_SIGNED_EN
module divider_32
  import divider_32_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        div_by_zero,
  output logic        busy
);

  state_t             state_q;
  state_t             state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   num_q;     // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0]   rem_q;     // partial remainder
  logic [WIDTH-1:0]   den_q;
  logic               dz_q;      // current operation is a divide by zero
  logic [WIDTH-1:0]   quo_out_q;
  logic [WIDTH-1:0]   rem_out_q;
  logic               dz_out_q;

  logic [WIDTH-1:0]   step_num;
  logic [WIDTH-1:0]   step_rem;
  logic [WIDTH-1:0]   dividend_mag;
  logic [WIDTH-1:0]   divisor_mag;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic               accept;

  assign accept = (state_q == IDLE) && in_valid;

  div_step_32 u_step (
    .rem_in  (rem_q),
    .num_in  (num_q),
    .den     (den_q),
    .rem_out (step_rem),
    .num_out (step_num)
  );

`ifdef DIVIDER_32_SIGNED_EN
  logic q_neg_q;
  logic r_neg_q;

  // Work on magnitudes; the final step applies the signs in the same cycle.
  assign dividend_mag = dividend[31] ? (~dividend + 32'd1) : dividend;
  assign divisor_mag  = divisor[31]  ? (~divisor + 32'd1)  : divisor;
  assign quo_fix      = q_neg_q ? (~step_num + 32'd1) : step_num;
  assign rem_fix      = r_neg_q ? (~step_rem + 32'd1) : step_rem;

  // Capture result signs at accept: quotient negative when signs differ,
  // remainder follows the dividend.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
    end else if (accept) begin
      q_neg_q <= dividend[31] ^ divisor[31];
      r_neg_q <= dividend[31];
    end
  end
`else
  assign dividend_mag = dividend;
  assign divisor_mag  = divisor;
  assign quo_fix      = step_num;
  assign rem_fix      = step_rem;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_d = RUN;
      end
      RUN: begin
        if (cnt_q == '0) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: load operands on accept, iterate in RUN, publish on the last step.
  // A zero divisor runs a single RUN cycle that just publishes the fixed result.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      num_q     <= '0;
      rem_q     <= '0;
      den_q     <= '0;
      dz_q      <= 1'b0;
      quo_out_q <= '0;
      rem_out_q <= '0;
      dz_out_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            rem_q <= '0;
            den_q <= divisor_mag;
            if (divisor == '0) begin
              dz_q  <= 1'b1;
              cnt_q <= '0;
              num_q <= dividend;
            end else begin
              dz_q  <= 1'b0;
              cnt_q <= CNT_INIT;
              num_q <= dividend_mag;
            end
          end
        end
        RUN: begin
          cnt_q <= cnt_q - 5'd1;
          num_q <= step_num;
          rem_q <= step_rem;
          if (cnt_q == '0) begin
            if (dz_q) begin
              quo_out_q <= DIV_ZERO_QUOTIENT;
              rem_out_q <= num_q;
              dz_out_q  <= 1'b1;
            end else begin
              quo_out_q <= quo_fix;
              rem_out_q <= rem_fix;
              dz_out_q  <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign quotient    = quo_out_q;
  assign remainder   = rem_out_q;
  assign div_by_zero = dz_out_q;

endmodule
